phase2_seq: RTL and testbench
=============================

# phase2_seq

Sequencer for the `phase2` gradient datapath. It latches one `h`/`y` operand pair, then fetches `N` packed columns one at a time from a column source. For each column it drives the datapath for a fixed latency and gathers the `N` 8-bit results into one packed gradient vector. It sits between the column storage/control logic and a single `phase2` instance, and owns that instance's `enable` and operand buses.

## Interface
Parameters:
- `DW`, 8: element width in bits.
- `N`, 8: elements per vector, and the number of columns per run.
- `N_BIT`, 3: width of the column index, log2(N).
- `LAT`, 2: cycles from a stable operand with `enable` high to a valid `g`. Must be ≥1.

Ports:
- `clk`, in, 1: the only clock. All state changes on the rising edge.
- `resetn`, in, 1: synchronous, active-low reset.
- `start`, in, 1: run request. Sampled only in IDLE.
- `abort`, in, 1: synchronous cancel of a run in progress.
- `h_in`, in, N*DW: prediction vector. Latched on an accepted `start`.
- `y_in`, in, N*DW: label vector. Latched on an accepted `start`.
- `col_req`, out, 1: request for column `col_idx`.
- `col_idx`, out, N_BIT: index of the requested column.
- `col_valid`, in, 1: column data valid. Meaningful only while `col_req`=1.
- `col_data`, in, N*DW: packed column; byte k is bits [k*DW +: DW].
- `p2_enable`, out, 1: `enable` of the `phase2` instance.
- `p2_x_col`, out, N*DW: `x_col` operand.
- `p2_h`, out, N*DW: `h` operand.
- `p2_y`, out, N*DW: `y` operand.
- `p2_g`, in, DW: `g` result.
- `busy`, out, 1: a run is in progress.
- `done`, out, 1: one-cycle pulse when a run completes.
- `grad_out`, out, N*DW: gradient vector; byte i is the result for column i.
- `grad_valid`, out, 1: `grad_out` holds a complete result.

## Operation
- **States:** IDLE, FETCH, RUN, DONE. Encoding is free.
- **IDLE:**
  - `start`=1 → latch `h_in`/`y_in` into `p2_h`/`p2_y`, set idx=0, clear `grad_out` and `grad_valid`, set `busy`=1, go to FETCH.
  - `start`=0 → stay in IDLE.
- **FETCH:**
  - Drive `col_req`=1 and `col_idx`=idx.
  - `col_valid`=1 at an edge → capture `col_data` into `p2_x_col`, clear the latency counter, go to RUN.
  - `col_valid`=0 → hold `col_req` and `col_idx` unchanged. There is no timeout.
- **RUN:**
  - `p2_enable`=1 for exactly `LAT` cycles. `p2_x_col`, `p2_h` and `p2_y` stay constant.
  - At the edge ending the `LAT`-th cycle, write `p2_g` into `grad_out[idx*DW +: DW]`.
  - If idx=N-1 → go to DONE. Otherwise idx+1 → go to FETCH.
- **DONE:**
  - For one cycle: `done`=1, `busy`=0, `grad_valid`=1. Then go to IDLE.
  - `grad_valid` and `grad_out` hold until the next accepted `start`.
- **`start`** outside IDLE, including the DONE cycle, is ignored (not queued).
- **`abort`** in FETCH or RUN → go to IDLE at that edge.
  - `busy`=0, no `done` pulse, `grad_valid` stays 0.
  - Partial `grad_out` bytes keep their values but are not valid.
- **`abort`** in IDLE or DONE has no effect.
- **Priority:** `resetn` > `abort` > `col_valid`.
- **Operands:** `h_in`, `y_in` and `col_data` are ignored at all times except their capture edges.
- **Arithmetic:** no arithmetic on data; `p2_g` bytes are copied verbatim. idx counts 0..N-1 and never wraps within a run.

## Timing
- **Reset** (`resetn`=0 at an edge; mid-run included) → IDLE on the next cycle. These outputs are 0: `busy`, `done`, `grad_valid`, `col_req`, `col_idx`, `p2_enable`, `p2_x_col`, `p2_h`, `p2_y`, `grad_out`.
- **`start` edge E0:** `busy` and `col_req` are 1 from the cycle after E0.
- **Per column:** (FETCH wait cycles, minimum 1) + `LAT` cycles.
- **With `col_valid` tied 1:** `done` is high in the cycle starting at edge E0 + N*(1+LAT). With N=8, LAT=2, that is 24 cycles after E0.
- **Column stall:** each cycle `col_valid` is low during FETCH adds exactly one cycle to the total.
- **Next run:** earliest accepted `start` is the cycle after DONE, giving back-to-back runs with one idle cycle.
- **Output type:** all outputs are registered; no combinational path from inputs to outputs.

## Test plan
- **Reset values:** hold `resetn`=0 for 3 cycles with random inputs → all outputs 0, `busy` stays 0.
- **Zero-wait run:** `col_valid`=1; column k source returns bytes k+1; `phase2` model returns g=k+0x10 for column k → `done` 24 cycles after `start`, `grad_out`=0x17161514_13121110, `grad_valid`=1.
- **Column stall:** hold `col_valid`=0 for 3 cycles on idx=3 → `col_req`=1 and `col_idx`=3 stable throughout, `p2_enable`=0, `done` at cycle 27, same `grad_out`.
- **Ignored `start`:** pulse `start` at cycles 5 and 24 (the DONE cycle) → no second run, `busy`=0 from cycle 25; change `h_in` mid-run → `p2_h` unchanged.
- **Abort:** `abort` during RUN of idx=4 → next cycle `busy`=0, `p2_enable`=0; no `done`, `grad_valid`=0; a new `start` runs cleanly to `done` 24 cycles later.
- **Reset mid-run:** `resetn`=0 during FETCH of idx=6 → all outputs 0 next cycle; a subsequent run completes in 24 cycles.

Source files
------------

// File: rtl/phase2_seq.sv
// phase2_seq: latches one h/y pair, fetches N columns in turn, drives phase2 and gathers N result bytes.
// Latency: N*(1+LAT) cycles from accepted start to the done pulse, plus one cycle per stalled FETCH cycle.
// Backpressure: col_req/col_idx hold until col_valid; start is ignored outside IDLE (not queued).
// Ports: clk/resetn (sync, active-low); start/abort run control; h_in/y_in operands latched on start;
//        col_req/col_idx/col_valid/col_data column fetch; p2_* drive and read one phase2 instance;
//        busy/done/grad_out/grad_valid run status and packed gradient (byte i = column i).
module phase2_seq #(
  parameter int DW    = 8,
  parameter int N     = 8,
  parameter int N_BIT = 3,
  parameter int LAT   = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [N*DW-1:0]   h_in,
  input  logic [N*DW-1:0]   y_in,
  output logic              col_req,
  output logic [N_BIT-1:0]  col_idx,
  input  logic              col_valid,
  input  logic [N*DW-1:0]   col_data,
  output logic              p2_enable,
  output logic [N*DW-1:0]   p2_x_col,
  output logic [N*DW-1:0]   p2_h,
  output logic [N*DW-1:0]   p2_y,
  input  logic [DW-1:0]     p2_g,
  output logic              busy,
  output logic              done,
  output logic [N*DW-1:0]   grad_out,
  output logic              grad_valid
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(LAT - 1);
  localparam logic [N_BIT-1:0] IDX_LAST = N_BIT'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_RUN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [N_BIT-1:0] idx;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             capture;
  logic             g_write;

  assign col_idx = idx;

  // Next state plus the one-cycle strobes that move data. abort outranks col_valid.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    g_write   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (col_valid) begin
          capture   = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (cnt == CNT_LAST) begin
          g_write   = 1'b1;
          state_nxt = (idx == IDX_LAST) ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      idx        <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      col_req    <= 1'b0;
      p2_enable  <= 1'b0;
      grad_valid <= 1'b0;
      p2_x_col   <= '0;
      p2_h       <= '0;
      p2_y       <= '0;
      grad_out   <= '0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt == S_FETCH) || (state_nxt == S_RUN);
      done      <= (state_nxt == S_DONE);
      col_req   <= (state_nxt == S_FETCH);
      p2_enable <= (state_nxt == S_RUN);

      if (accept) begin
        p2_h       <= h_in;
        p2_y       <= y_in;
        idx        <= '0;
        grad_out   <= '0;
        grad_valid <= 1'b0;
      end

      // cnt counts enabled cycles of the current column; restarted on every capture.
      if (capture) begin
        p2_x_col <= col_data;
        cnt      <= '0;
      end else if (state == S_RUN) begin
        cnt <= cnt + CW'(1);
      end

      if (g_write) begin
        for (int k = 0; k < N; k++) begin
          if (idx == N_BIT'(k)) begin
            grad_out[k*DW +: DW] <= p2_g;
          end
        end
        // idx stops at N-1 so it never wraps within a run.
        if (idx != IDX_LAST) begin
          idx <= idx + N_BIT'(1);
        end
      end

      if (state_nxt == S_DONE) begin
        grad_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_phase2_seq.sv
// tb_phase2_seq: directed bench for phase2_seq with a column source and a phase2 stand-in.
// Latency: n/a.
// Backpressure: col_valid is driven by the test sequences to create FETCH stalls.
module tb_phase2_seq;

  localparam int DW = 8;
  localparam int N = 8;
  localparam int N_BIT = 3;
  localparam int LAT = 2;
  localparam logic [63:0] H0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] Y0 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] GRAD_EXP = 64'h1716_1514_1312_1110;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              col_valid = 1'b1;
  logic [N*DW-1:0]   h_in = '0;
  logic [N*DW-1:0]   y_in = '0;
  logic [N*DW-1:0]   col_data;
  logic              col_req;
  logic [N_BIT-1:0]  col_idx;
  logic              p2_enable;
  logic [N*DW-1:0]   p2_x_col;
  logic [N*DW-1:0]   p2_h;
  logic [N*DW-1:0]   p2_y;
  logic [DW-1:0]     p2_g;
  logic              busy;
  logic              done;
  logic [N*DW-1:0]   grad_out;
  logic              grad_valid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int e0 = 0;

  phase2_seq #(.DW(DW), .N(N), .N_BIT(N_BIT), .LAT(LAT)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .h_in(h_in), .y_in(y_in),
    .col_req(col_req), .col_idx(col_idx), .col_valid(col_valid), .col_data(col_data),
    .p2_enable(p2_enable), .p2_x_col(p2_x_col), .p2_h(p2_h), .p2_y(p2_y), .p2_g(p2_g),
    .busy(busy), .done(done), .grad_out(grad_out), .grad_valid(grad_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Column k returns every byte equal to k+1.
  always_comb begin
    col_data = '0;
    for (int j = 0; j < N; j++) col_data[j*DW +: DW] = 8'(col_idx) + 8'd1;
  end

  // phase2 stand-in: g = k+0x10 for column k while enabled, a marker value otherwise.
  always_comb begin
    p2_g = 8'hEE;
    if (p2_enable) p2_g = p2_x_col[7:0] + 8'h0F;
  end

  typedef struct {
    logic       start;
    logic       busy;
    logic       col_req;
    logic [2:0] idx;
    logic       en;
    logic       done;
    logic       gv;
  } vec_t;

  vec_t tbl [27];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    e0 = cyc;
  endtask

  task automatic goto_cycle(input int n);
    @(negedge clk);
    while ((cyc - e0) < n) @(negedge clk);
  endtask

  task automatic wait_done(input int exp_lat, input string name);
    @(negedge clk);
    while (!done && (cyc - e0) < 100) @(negedge clk);
    chk({name, " done"}, 64'(done), 64'd1);
    chk({name, " latency"}, 64'(cyc - e0), 64'(exp_lat));
    chk({name, " grad_out"}, grad_out, GRAD_EXP);
    chk({name, " grad_valid"}, 64'(grad_valid), 64'd1);
  endtask

  task automatic chk_zero(input string name);
    chk({name, " flags"}, 64'({busy, done, grad_valid, col_req, col_idx, p2_enable}), 64'd0);
    chk({name, " x_col"}, p2_x_col, 64'd0);
    chk({name, " h_y"}, p2_h | p2_y, 64'd0);
    chk({name, " grad_out"}, grad_out, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic       saw_done;

    // Expected per-cycle trace of a zero-wait run, with start pulses at cycles 5 and 24.
    for (int c = 0; c < 24; c++) begin
      tbl[c].start   = (c == 5);
      tbl[c].busy    = 1'b1;
      tbl[c].col_req = ((c % 3) == 0);
      tbl[c].idx     = 3'(c / 3);
      tbl[c].en      = ((c % 3) != 0);
      tbl[c].done    = 1'b0;
      tbl[c].gv      = 1'b0;
    end
    for (int c = 24; c < 27; c++) begin
      tbl[c].start   = (c == 24);
      tbl[c].busy    = 1'b0;
      tbl[c].col_req = 1'b0;
      tbl[c].idx     = 3'd7;
      tbl[c].en      = 1'b0;
      tbl[c].done    = (c == 24);
      tbl[c].gv      = 1'b1;
    end

    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'($urandom);
      abort = 1'($urandom);
      col_valid = 1'($urandom);
      h_in = {$urandom, $urandom};
      y_in = {$urandom, $urandom};
      @(negedge clk);
      chk_zero("reset");
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    col_valid = 1'b1;
    h_in = H0;
    y_in = Y0;
    resetn = 1'b1;

    // Zero-wait run, ignored starts and mid-run h_in change, checked cycle by cycle.
    do_start();
    for (int c = 0; c < 27; c++) begin
      @(negedge clk);
      chk($sformatf("trace c%0d flags", c),
          64'({busy, col_req, p2_enable, done, grad_valid}),
          64'({tbl[c].busy, tbl[c].col_req, tbl[c].en, tbl[c].done, tbl[c].gv}));
      if (tbl[c].busy) chk($sformatf("trace c%0d col_idx", c), 64'(col_idx), 64'(tbl[c].idx));
      if (tbl[c].en) begin
        b = 8'(tbl[c].idx) + 8'd1;
        chk($sformatf("trace c%0d x_col", c), p2_x_col, {8{b}});
      end
      chk($sformatf("trace c%0d p2_h", c), p2_h, H0);
      if (c >= 24) chk($sformatf("trace c%0d grad_out", c), grad_out, GRAD_EXP);
      start = tbl[c].start;
      if (c == 10) h_in = {$urandom, $urandom};
    end
    start = 1'b0;
    chk("trace p2_y", p2_y, Y0);

    // Three-cycle column stall on idx 3.
    do_start();
    goto_cycle(9);
    chk("stall entry", 64'({col_req, col_idx}), 64'({1'b1, 3'd3}));
    col_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("stall hold %0d", i), 64'({col_req, col_idx, p2_enable}), 64'({1'b1, 3'd3, 1'b0}));
    end
    col_valid = 1'b1;
    wait_done(27, "stall");

    // Abort during RUN of idx 4, then a clean run.
    do_start();
    goto_cycle(13);
    chk("abort entry", 64'({col_idx, p2_enable}), 64'({3'd4, 1'b1}));
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort next", 64'({busy, p2_enable, col_req, done, grad_valid}), 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || grad_valid) saw_done = 1'b1;
    end
    chk("abort no done", 64'(saw_done), 64'd0);
    do_start();
    wait_done(24, "after abort");

    // Reset during FETCH of idx 6, then a clean run.
    do_start();
    goto_cycle(18);
    chk("midreset entry", 64'({col_req, col_idx}), 64'({1'b1, 3'd6}));
    resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk_zero("midreset");
    do_start();
    wait_done(24, "after reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
